button_event_decoder: RTL and testbench

//   Consumes one debounced push-button level and turns it into discrete events
//   for the clock/alarm set logic: press, release, long-press, auto-repeat.

---
 rtl/button_event_decoder_if.sv | 23 ++
 rtl/button_event_decoder.sv | 106 ++++++++++
 tb/tb_button_event_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// Button decoder bus: timebase/enable/level in, event strobes out.
// release and repeat are SV keywords, hence the _ev suffix on those two strobes.
interface button_event_decoder_if;
   logic tick;
   logic en;
   logic btn;
   logic press;
   logic release_ev;
   logic long_press;
   logic repeat_ev;
   logic step;
   logic held;

   modport master (
      output tick, en, btn,
      input  press, release_ev, long_press, repeat_ev, step, held
   );

   modport slave (
      input  tick, en, btn,
      output press, release_ev, long_press, repeat_ev, step, held
   );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long-press/auto-repeat
// strobes, counting hold time in timebase ticks rather than clock cycles.
module button_event_decoder #(
   parameter int CNT_W        = 8,
   parameter int LONG_TICKS   = 50,
   parameter int REPEAT_TICKS = 10
) (
   input logic              clk,
   input logic              rst,
   button_event_decoder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             btn_q;
   logic             press_r, release_r, long_r, repeat_r, step_r, held_r;

   // btn_q resets high so a button held through reset must be seen low before it can press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         btn_q     <= 1'b1;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
         step_r    <= 1'b0;
         held_r    <= 1'b0;
      end else begin
         btn_q     <= bus.btn;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
         step_r    <= 1'b0;
         held_r    <= 1'b0;
         if (!bus.en) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.btn && !btn_q) begin
                     state   <= PRESSED;
                     cnt     <= '0;
                     press_r <= 1'b1;
                     step_r  <= 1'b1;
                  end
               end
               PRESSED: begin
                  if (!bus.btn) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     release_r <= 1'b1;
                  end else if (bus.tick) begin
                     if (cnt == LONG_LAST) begin
                        state  <= HELD;
                        cnt    <= '0;
                        long_r <= 1'b1;
                        held_r <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               HELD: begin
                  if (!bus.btn) begin
                     state     <= IDLE;
                     cnt       <= '0;
                     release_r <= 1'b1;
                  end else begin
                     held_r <= 1'b1;
                     if (bus.tick) begin
                        if (cnt == REPEAT_LAST) begin
                           cnt      <= '0;
                           repeat_r <= 1'b1;
                           step_r   <= 1'b1;
                        end else begin
                           cnt <= cnt + 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.press      = press_r;
   assign bus.release_ev = release_r;
   assign bus.long_press = long_r;
   assign bus.repeat_ev  = repeat_r;
   assign bus.step       = step_r;
   assign bus.held       = held_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG_TICKS=4, REPEAT_TICKS=2, tick every 4th clk).
module tb_button_event_decoder;

   localparam logic [3:0] K_PRESS = 4'b1000;
   localparam logic [3:0] K_REL   = 4'b0100;
   localparam logic [3:0] K_LONG  = 4'b0010;
   localparam logic [3:0] K_REP   = 4'b0001;

   typedef struct {
      logic [3:0] kind;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tph = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   button_event_decoder_if bif ();

   button_event_decoder #(
      .CNT_W(8),
      .LONG_TICKS(4),
      .REPEAT_TICKS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] evs();
      return {bif.press, bif.release_ev, bif.long_press, bif.repeat_ev};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard monitor: pops an expectation whenever the DUT shows an event.
   always @(negedge clk) begin
      if (!rst) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missing_event", 0, int'(q[0].kind));
            void'(q.pop_front());
         end
         if (evs() != 4'b0000) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
               chk("unexpected_event", int'(evs()), 0);
            end else begin
               chk("event_kind", int'(evs()), int'(q[0].kind));
               chk("held_at_event", int'(bif.held),
                   int'(q[0].kind == K_LONG || q[0].kind == K_REP));
               void'(q.pop_front());
            end
         end
         chk("step_strobe", int'(bif.step), int'(bif.press | bif.repeat_ev));
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
      bif.tick = (tph == 3);
      tph = (tph + 1) % 4;
   endtask

   task automatic push(input logic [3:0] kind);
      q.push_back('{kind, cyc + 1});
   endtask

   task automatic press_now();
      bif.btn = 1'b1;
      push(K_PRESS);
   endtask

   task automatic release_now();
      bif.btn = 1'b0;
      push(K_REL);
   endtask

   // Keep btn high for n counted ticks; long on the 4th, repeat every 2nd after.
   task automatic hold(input int n);
      int k;
      k = 0;
      while (k < n) begin
         next();
         if (bif.tick) begin
            k++;
            if (k == 4) push(K_LONG);
            else if (k > 4 && ((k - 4) % 2) == 0) push(K_REP);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) next();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      bif.tick = 1'b0;
      bif.en   = 1'b1;
      bif.btn  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_events", int'(evs()), 0);
      chk("reset_step", int'(bif.step), 0);
      chk("reset_held", int'(bif.held), 0);
      rst = 1'b0;
      idle(3);

      // 1: short press of two ticks
      press_now();
      hold(2);
      next();
      release_now();
      idle(6);

      // 2: held for ten ticks
      next();
      press_now();
      hold(10);
      next();
      release_now();
      idle(6);

      // 3: release coincides with the long-press tick
      press_now();
      hold(3);
      do next(); while (!bif.tick);
      release_now();
      idle(6);
      chk("t3_held", int'(bif.held), 0);

      // 4: reset while held with btn kept high
      press_now();
      hold(5);
      next();
      rst = 1'b1;
      #1;
      chk("t4_rst_events", int'(evs()), 0);
      chk("t4_rst_held", int'(bif.held), 0);
      next();
      rst = 1'b0;
      idle(10);
      chk("t4_after_held", int'(bif.held), 0);
      bif.btn = 1'b0;
      next();
      press_now();
      hold(1);
      next();
      release_now();
      idle(6);

      // 5: en dropped while held, then raised with btn high
      press_now();
      hold(5);
      next();
      bif.en = 1'b0;
      next();
      chk("t5_held_off", int'(bif.held), 0);
      bif.en = 1'b1;
      idle(8);
      chk("t5_no_press_held", int'(bif.held), 0);
      bif.btn = 1'b0;
      next();
      press_now();
      next();
      release_now();
      idle(6);

      // 6: press accepted in a tick cycle; that tick is not counted
      do next(); while (!bif.tick);
      press_now();
      hold(4);
      next();
      chk("t6_held", int'(bif.held), 1);
      release_now();
      idle(8);

      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
